hazard_stall_controller: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It decides, cycle by cycle, whether the pipeline advances, stalls with a bubble, flushes IF/ID, or freezes completely. It works alongside the forwarding unit and covers the hazards forwarding cannot resolve: load-use, ID-stage branch operands, taken branches/jumps, and a data memory that is not ready. It sits in the ID stage and drives PC, IF/ID and ID/EX register controls.

---
 rtl/hazard_pkg.sv | 7 +
 rtl/hazard_reg_match.sv | 12 +
 rtl/hazard_stall_controller.sv | 99 +++++++++
 tb/tb_hazard_stall_controller.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encodings and bubble counts for the hazard stall controller.
package hazard_pkg;
   typedef enum logic [1:0] {HZ_RUN = 2'b00, HZ_STALL = 2'b01} hz_state_t;
   localparam int BUBBLES_LOAD    = 1;
   localparam int BUBBLES_LOAD_BR = 2;
   localparam int BUBBLES_ALU_BR  = 1;
endpackage

// File: rtl/hazard_reg_match.sv
// hazard_reg_match: compares one EX-stage destination against the rs/rt sources of the ID instruction.
module hazard_reg_match (
   input  logic [4:0] dst,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       uses_rt,
   output logic       rs_hit,
   output logic       rt_hit
);
   assign rs_hit = (dst != 5'd0) && (dst == rs);
   assign rt_hit = (dst != 5'd0) && uses_rt && (dst == rt);
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use / ID-branch stall, flush and memory freeze control.
// Optional HAZARD_PERF_CNT_EN adds saturating stall and flush event counters.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int STALL_W = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_ID_EX_MemRead,
   input  logic             in_ID_EX_RegWrite,
   input  logic [4:0]       in_ID_EX_Rt_address_5,
   input  logic [4:0]       in_ID_EX_Rd_address_5,
   input  logic [4:0]       in_IF_ID_Rs_address_5,
   input  logic [4:0]       in_IF_ID_Rt_address_5,
   input  logic             in_IF_ID_UsesRt,
   input  logic             in_IF_ID_Branch,
   input  logic             in_branch_taken,
   input  logic             in_jump,
   input  logic             in_mem_ready,
   output logic             o_PC_write,
   output logic             o_IF_ID_write,
   output logic             o_ID_EX_bubble,
   output logic             o_IF_ID_flush,
   output logic             o_freeze,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
`endif
   output logic [1:0]       o_state_2
);
   hz_state_t          state, state_nx;
   logic [STALL_W-1:0] cnt, cnt_nx, n;
   logic               ld_rs, ld_rt, alu_rs, alu_rt, load_use, alu_br;
   logic [4:0]         ctl;

   hazard_reg_match u_load (
      .dst(in_ID_EX_Rt_address_5), .rs(in_IF_ID_Rs_address_5), .rt(in_IF_ID_Rt_address_5),
      .uses_rt(in_IF_ID_UsesRt), .rs_hit(ld_rs), .rt_hit(ld_rt)
   );

   hazard_reg_match u_alu (
      .dst(in_ID_EX_Rd_address_5), .rs(in_IF_ID_Rs_address_5), .rt(in_IF_ID_Rt_address_5),
      .uses_rt(in_IF_ID_UsesRt), .rs_hit(alu_rs), .rt_hit(alu_rt)
   );

   assign load_use = in_ID_EX_MemRead && (ld_rs || ld_rt);
   assign alu_br   = in_IF_ID_Branch && in_ID_EX_RegWrite && !in_ID_EX_MemRead && (alu_rs || alu_rt);
   assign n = (load_use && in_IF_ID_Branch) ? STALL_W'(BUBBLES_LOAD_BR) :
              load_use                      ? STALL_W'(BUBBLES_LOAD)    :
              alu_br                        ? STALL_W'(BUBBLES_ALU_BR)  : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= HZ_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // The first bubble is issued from RUN, so STALL only covers the remaining n-1.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (in_mem_ready && state == HZ_STALL) begin
         cnt_nx   = (cnt > STALL_W'(1)) ? cnt - STALL_W'(1) : '0;
         state_nx = (cnt > STALL_W'(1)) ? HZ_STALL : HZ_RUN;
      end else if (in_mem_ready && n > STALL_W'(1)) begin
         cnt_nx   = n - STALL_W'(1);
         state_nx = HZ_STALL;
      end
   end

   // ctl = {pc_write, if_id_write, bubble, flush, freeze}
   always_comb begin
      ctl = reset                             ? 5'b00100 :
            !in_mem_ready                     ? 5'b00001 :
            (state == HZ_STALL || n != '0)    ? 5'b00100 :
            (in_branch_taken || in_jump)      ? 5'b11010 : 5'b11000;
   end

   assign {o_PC_write, o_IF_ID_write, o_ID_EX_bubble, o_IF_ID_flush, o_freeze} = ctl;
   assign o_state_2 = reset ? HZ_RUN : state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_ID_EX_bubble && !o_freeze && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
         if (o_IF_ID_flush && !o_freeze && !(&o_flush_cnt)) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed stimulus checked every cycle against a bubble-count model.
module tb_hazard_stall_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mr = 0, rw = 0, ur = 0, br = 0, bt = 0, jp = 0, rdy = 1;
   logic [4:0] ert = 0, erd = 0, rs = 0, rt = 0;
   logic       pc_w, ifid_w, bub, fl, frz;
   logic [1:0] st;
   int         checks = 0, failures = 0;
   int         rem = 0;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
   int          m_stall = 0, m_flush = 0;
`endif

   always #5 clk = ~clk;

   hazard_stall_controller dut (
      .clk(clk), .reset(reset),
      .in_ID_EX_MemRead(mr), .in_ID_EX_RegWrite(rw),
      .in_ID_EX_Rt_address_5(ert), .in_ID_EX_Rd_address_5(erd),
      .in_IF_ID_Rs_address_5(rs), .in_IF_ID_Rt_address_5(rt),
      .in_IF_ID_UsesRt(ur), .in_IF_ID_Branch(br),
      .in_branch_taken(bt), .in_jump(jp), .in_mem_ready(rdy),
      .o_PC_write(pc_w), .o_IF_ID_write(ifid_w), .o_ID_EX_bubble(bub),
      .o_IF_ID_flush(fl), .o_freeze(frz),
`ifdef HAZARD_PERF_CNT_EN
      .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt),
`endif
      .o_state_2(st)
   );

   wire [6:0] act = {pc_w, ifid_w, bub, fl, frz, st};

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, a, e);
      end
   endtask

   function automatic bit hit(input logic [4:0] x);
      return x != 0 && (x == rs || (ur && x == rt));
   endfunction

   function automatic int bubbles();
      bit lu = mr && hit(ert);
      bit ab = br && rw && !mr && hit(erd);
      return (lu && br) ? 2 : (lu || ab) ? 1 : 0;
   endfunction

   // expected {pc_write, if_id_write, bubble, flush, freeze, state}
   function automatic logic [6:0] model_out();
      if (reset) return 7'b0010000;
      if (!rdy) return {5'b00001, (rem > 0) ? 2'b01 : 2'b00};
      if (rem > 0) return 7'b0010001;
      if (bubbles() > 0) return 7'b0010000;
      if (bt || jp) return 7'b1101000;
      return 7'b1100000;
   endfunction

   always @(posedge clk or posedge reset) begin
      logic [6:0] o;
      o = model_out();
      if (reset) begin
         rem <= 0;
`ifdef HAZARD_PERF_CNT_EN
         m_stall <= 0;
         m_flush <= 0;
`endif
      end else if (rdy) begin
         rem <= (rem > 0) ? rem - 1 : (bubbles() > 0 ? bubbles() - 1 : 0);
`ifdef HAZARD_PERF_CNT_EN
         if (o[4] && m_stall < 65535) m_stall <= m_stall + 1;
         if (o[3] && m_flush < 65535) m_flush <= m_flush + 1;
`endif
      end
   end

   always @(negedge clk) begin
      chk("model", 32'(act), 32'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
   end

   task automatic apply(input logic a_mr, a_rw, input logic [4:0] a_ert, a_erd, a_rs, a_rt,
                        input logic a_ur, a_br, a_bt, a_jp, a_rdy);
      @(posedge clk);
      #1;
      {mr, rw, ert, erd, rs, rt, ur, br, bt, jp, rdy} = {a_mr, a_rw, a_ert, a_erd, a_rs, a_rt, a_ur, a_br, a_bt, a_jp, a_rdy};
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic load_br(input logic a_rdy);
      apply(1, 0, 8, 0, 0, 8, 1, 1, 0, 0, a_rdy);
   endtask

   initial begin
      #2;
      chk("reset_out", 32'(act), 32'b0010000);
      @(posedge clk);
      #1 reset = 0;
      idle();
      chk("idle", 32'(act), 32'b1100000);
      apply(1, 0, 8, 0, 8, 0, 0, 0, 0, 0, 1);
      chk("load_use", 32'(act), 32'b0010000);
      idle();
      chk("load_use_after", 32'(act), 32'b1100000);
      load_br(1);
      chk("load_br_1", 32'(act), 32'b0010000);
      load_br(1);
      chk("load_br_2", 32'(act), 32'b0010001);
      idle();
      chk("load_br_done", 32'(act), 32'b1100000);
      apply(0, 1, 0, 9, 9, 0, 0, 1, 0, 0, 1);
      chk("alu_br", 32'(act), 32'b0010000);
      idle();
      apply(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      chk("alu_br_r0", 32'(act), 32'b1100000);
      apply(1, 0, 8, 0, 0, 8, 0, 0, 0, 0, 1);
      chk("rt_unused", 32'(act), 32'b1100000);
      apply(0, 1, 0, 9, 9, 0, 0, 0, 0, 0, 1);
      chk("alu_nobranch", 32'(act), 32'b1100000);
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
      chk("taken_flush", 32'(act), 32'b1101000);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("jump_flush", 32'(act), 32'b1101000);
      apply(1, 0, 8, 0, 8, 0, 0, 0, 1, 0, 1);
      chk("taken_hazard", 32'(act), 32'b0010000);
      apply(1, 0, 8, 0, 8, 0, 0, 0, 0, 0, 0);
      chk("freeze_run", 32'(act), 32'b0000100);
      apply(1, 0, 8, 0, 8, 0, 0, 0, 0, 0, 1);
      chk("freeze_reeval", 32'(act), 32'b0010000);
      load_br(1);
      chk("fz_stall_entry", 32'(act), 32'b0010000);
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         chk("freeze_stall", 32'(act), 32'b0000101);
      end
      idle();
      chk("fz_stall_resume", 32'(act), 32'b0010001);
      idle();
      chk("fz_stall_run", 32'(act), 32'b1100000);
      load_br(1);
      @(posedge clk);
      #1;
      {mr, rw, ert, erd, rs, rt, ur, br, bt, jp, rdy} = '0;
      rdy = 1;
      #1;
      chk("in_stall", 32'(st), 32'b01);
      #1 reset = 1;
      #1;
      chk("reset_mid_stall", 32'(act), 32'b0010000);
      @(posedge clk);
      #1 reset = 0;
      #1;
      chk("after_reset", 32'(act), 32'b1100000);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt_reset", 32'(stall_cnt), 32'd0);
      chk("flush_cnt_reset", 32'(flush_cnt), 32'd0);
`endif
      idle();
      chk("idle_end", 32'(act), 32'b1100000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
